// File: rtl/spram_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : spram_pkg
//  Purpose : Shared types and helpers for the byte-masked single-port RAM
//            controller (state encoding, lane count, lane merge).
//  Ports   : none (package)
//  Config  : none
//  Rev     : 1.0  initial release
// ============================================================================
package spram_pkg;

   localparam int c_LANE_W = 8;

   // Clear sequencer / run states
   typedef enum logic [1:0] {
      CLR  = 2'd0,
      DONE = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Number of byte lanes in a word of width dsz
   function automatic int nlane(input int dsz);
      return dsz / c_LANE_W;
   endfunction

   // Byte-lane merge: enabled lane takes the new byte, otherwise keeps the old
   function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spram_bank.sv
`default_nettype none
// ============================================================================
//  Module  : spram_bank
//  Purpose : Raw 2**ASZ x DSZ storage array, single port, per-byte-lane write
//            enable and registered read data.
//  Ports   : clk, rst        clock / synchronous active-high reset
//            addr  [ASZ]     word address (shared by read and write)
//            wen   [DSZ/8]   per-lane write enable
//            wdata [DSZ]     write data
//            re              read enable; rdata loads mem[addr] on the edge
//            rdata [DSZ]     registered read data, holds between reads
//  Config  : none
//  Rev     : 1.0  initial release
// ============================================================================
module spram_bank #(
   parameter int ASZ = 15,
   parameter int DSZ = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ASZ-1:0]   addr,
   input  logic [DSZ/8-1:0] wen,
   input  logic [DSZ-1:0]   wdata,
   input  logic             re,
   output logic [DSZ-1:0]   rdata
);

   localparam int c_NLANE = DSZ / 8;
   localparam int c_DEPTH = 2 ** ASZ;

   logic [DSZ-1:0] r_mem [0:c_DEPTH-1];
   logic [DSZ-1:0] r_rdata;

   // Array contents are not reset; the controller's clear sequencer
   // provides known contents instead.
   always_ff @(posedge clk) begin
      for (int k = 0; k < c_NLANE; k++) begin
         if (wen[k]) begin
            r_mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
         end
      end
   end

   // Read register only moves on a read, so writes never disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/spram_bmsk_ctl.sv
`default_nettype none
// ============================================================================
//  Module  : spram_bmsk_ctl
//  Purpose : Parametrised single-port RAM with byte-lane write mask,
//            req/rdy/vld handshake and a post-reset clear sequencer that
//            writes CLR_VAL to every word before accepting requests.
//  Ports   : clk, rst        clock / synchronous active-high reset
//            req, we         request valid / write(1) read(0)
//            bmsk [DSZ/8]    byte-lane write enable (ignored on reads)
//            ai   [ASZ]      word address
//            vi   [DSZ]      write data
//            rdy             ready to accept a request
//            vo   [DSZ]      read data, valid when vld
//            vld             one-cycle read data strobe
//  Config  : SPRAM_OREG_EN   adds an output register stage (read latency 2)
//  Rev     : 1.0  initial release
// ============================================================================
module spram_bmsk_ctl
   import spram_pkg::*;
#(
   parameter int             ASZ      = 15,
   parameter int             DSZ      = 32,
   parameter logic [DSZ-1:0] CLR_VAL  = '0,
   parameter bit             CLR_SKIP = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             we,
   input  logic [DSZ/8-1:0] bmsk,
   input  logic [ASZ-1:0]   ai,
   input  logic [DSZ-1:0]   vi,
   output logic             rdy,
   output logic [DSZ-1:0]   vo,
   output logic             vld
);

   localparam int             c_NLANE    = nlane(DSZ);
   localparam logic [ASZ-1:0] c_CNT_LAST = '1;
   localparam logic [ASZ-1:0] c_CNT_ONE  = 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ASZ-1:0]       r_cnt;
   logic                 r_vld;

   logic                 w_rdy;
   logic [ASZ-1:0]       w_addr;
   logic [c_NLANE-1:0]   w_wen;
   logic [DSZ-1:0]       w_wdata;
   logic                 w_re;
   logic [DSZ-1:0]       w_rdata;

   // ---------------------------------------------------------------------
   // State and clear counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLR_SKIP ? DONE : CLR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == CLR) begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next state and bank port mux: the clear sequencer owns the bank until
   // RUN, after which the user port drives it directly.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_rdy       = 1'b0;
      w_addr      = ai;
      w_wen       = '0;
      w_wdata     = vi;
      w_re        = 1'b0;
      case (r_state)
         CLR: begin
            w_addr  = r_cnt;
            w_wen   = '1;
            w_wdata = CLR_VAL;
            if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = RUN;
         end
         RUN: begin
            w_rdy = 1'b1;
            if (req) begin
               if (we) begin
                  w_wen = bmsk;
               end else begin
                  w_re = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = CLR;
         end
      endcase
   end

   spram_bank #(
      .ASZ (ASZ),
      .DSZ (DSZ)
   ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .addr  (w_addr),
      .wen   (w_wen),
      .wdata (w_wdata),
      .re    (w_re),
      .rdata (w_rdata)
   );

   // Read strobe tracks the bank's read register one edge behind the accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= 1'b0;
      end else begin
         r_vld <= w_re;
      end
   end

   assign rdy = w_rdy;

`ifdef SPRAM_OREG_EN
   logic           r_vld_o;
   logic [DSZ-1:0] r_vo_o;

   // Data and strobe move together; data only loads on a valid read so vo
   // keeps holding the last read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_o <= 1'b0;
         r_vo_o  <= '0;
      end else begin
         r_vld_o <= r_vld;
         if (r_vld) begin
            r_vo_o <= w_rdata;
         end
      end
   end

   assign vld = r_vld_o;
   assign vo  = r_vo_o;
`else
   assign vld = r_vld;
   assign vo  = w_rdata;
`endif

endmodule
`default_nettype wire
